// File: rtl/parallel_pixel_store_pkg.sv
// Shared widths, store-path FSM encodings and defaults for the pixel write-back path.
package parallel_pixel_store_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int PIXEL_WIDTH = 8;
  localparam int NUM_PIXELS  = 8;
  localparam int ADDR_WIDTH  = 12;
  localparam int WORD_WIDTH  = NUM_PIXELS * DATA_WIDTH;
  localparam int MEM_WIDTH   = NUM_PIXELS * PIXEL_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/parallel_pixel_store_saturate.sv
// One lane of the write-back path: arithmetic right shift, then clamp to an unsigned pixel.
module parallel_pixel_store_saturate
  import parallel_pixel_store_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_WIDTH,
  parameter int SHIFT   = 0
) (
  input  logic [DATA_WIDTH-1:0] lane_i,
  output logic [PIXEL_W-1:0]    pix_o,
  output logic                  sat_o
);

  localparam logic signed [DATA_WIDTH-1:0] PIX_MAX = DATA_WIDTH'((2 ** PIXEL_W) - 1);

  logic signed [DATA_WIDTH-1:0] shifted;
  logic                         is_neg;
  logic                         is_over;

  always_comb begin
    shifted = $signed(lane_i) >>> SHIFT;
    is_neg  = shifted[DATA_WIDTH-1];
    is_over = !is_neg && (shifted > PIX_MAX);
    sat_o   = is_neg || is_over;
    if (is_neg) begin
      pix_o = '0;
    end else if (is_over) begin
      pix_o = '1;
    end else begin
      pix_o = shifted[PIXEL_W-1:0];
    end
  end

endmodule

// File: rtl/parallel_pixel_store.sv
// Pixel write-back: latches the destination address, converts one PE result word to packed
// 8-bit pixels and issues a single held memory write, then pulses store_done.
//
//  state    | meaning
//  ST_IDLE  | waiting for store_start with store_en
//  ST_WAIT  | address latched, store_ready high, waiting for pixel_valid_in
//  ST_WRITE | mem_wr_en high, held until mem_wr_ready
//  ST_DONE  | one-cycle store_done pulse
module parallel_pixel_store
  import parallel_pixel_store_pkg::*;
#(
  parameter int PIXEL_W  = PIXEL_WIDTH,
  parameter int NUM_PIX  = NUM_PIXELS,
  parameter int ADDR_W   = ADDR_WIDTH,
  parameter int MEM_W    = MEM_WIDTH,
  parameter int SHIFT    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          store_en,
  input  logic                          store_start,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [ADDR_W-1:0]             row_offset,
  input  logic [ADDR_W-1:0]             col_offset,
  input  logic [NUM_PIX*DATA_WIDTH-1:0] pixel_word_in,
  input  logic                          pixel_valid_in,
  output logic                          store_ready,
  output logic                          mem_wr_en,
  output logic [ADDR_W-1:0]             mem_wr_addr,
  output logic [MEM_W-1:0]              mem_wr_data,
  input  logic                          mem_wr_ready,
  output logic                          store_done,
  output logic [3:0]                    sat_count
);

  logic [1:0]          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [MEM_W-1:0]    wr_data_q;
  logic [3:0]          sat_count_q;

  logic [ADDR_W-1:0]   addr_sum;
  logic [MEM_W-1:0]    packed_pix;
  logic [NUM_PIX-1:0]  sat_vec;
  logic [3:0]          sat_total;
  logic                start_ok;
  logic                capture;

  for (genvar k = 0; k < NUM_PIX; k++) begin : g_lane
    parallel_pixel_store_saturate #(
      .PIXEL_W (PIXEL_W),
      .SHIFT   (SHIFT)
    ) u_sat (
      .lane_i (pixel_word_in[k*DATA_WIDTH +: DATA_WIDTH]),
      .pix_o  (packed_pix[k*PIXEL_W +: PIXEL_W]),
      .sat_o  (sat_vec[k])
    );
  end

  // Carry out of the address adder is intentionally dropped (wraps within the buffer).
  assign addr_sum = base_addr + row_offset + col_offset;

  always_comb begin
    sat_total = '0;
    for (int k = 0; k < NUM_PIX; k++) begin
      sat_total = sat_total + {3'b000, sat_vec[k]};
    end
  end

  assign start_ok = (state_q == ST_IDLE) && store_start && store_en;
  assign capture  = (state_q == ST_WAIT) && store_en && pixel_valid_in;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (store_start && store_en) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Dropping the enable abandons the request before anything reaches memory.
        if (!store_en) begin
          state_d = ST_IDLE;
        end else if (pixel_valid_in) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mem_wr_ready) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      sat_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        addr_q <= addr_sum;
      end
      if (capture) begin
        wr_addr_q   <= addr_q;
        wr_data_q   <= packed_pix;
        sat_count_q <= sat_total;
      end
    end
  end

  // Handshake outputs decode the registered state, so async reset clears them at once.
  assign store_ready = (state_q == ST_WAIT);
  assign mem_wr_en   = (state_q == ST_WRITE);
  assign store_done  = (state_q == ST_DONE);
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign sat_count   = sat_count_q;

endmodule

// File: tb/tb_parallel_pixel_store.sv
// Directed bench for parallel_pixel_store: basic, clamp, address wrap, backpressure,
// enable handling and asynchronous reset during a write.
module tb_parallel_pixel_store;

  logic         clk;
  logic         rst;
  logic         store_en;
  logic         store_start;
  logic [11:0]  base_addr;
  logic [11:0]  row_offset;
  logic [11:0]  col_offset;
  logic [127:0] pixel_word_in;
  logic         pixel_valid_in;
  logic         store_ready;
  logic         mem_wr_en;
  logic [11:0]  mem_wr_addr;
  logic [63:0]  mem_wr_data;
  logic         mem_wr_ready;
  logic         store_done;
  logic [3:0]   sat_count;

  int errors = 0;
  int checks = 0;

  parallel_pixel_store dut (
    .clk            (clk),
    .rst            (rst),
    .store_en       (store_en),
    .store_start    (store_start),
    .base_addr      (base_addr),
    .row_offset     (row_offset),
    .col_offset     (col_offset),
    .pixel_word_in  (pixel_word_in),
    .pixel_valid_in (pixel_valid_in),
    .store_ready    (store_ready),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_addr    (mem_wr_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_wr_ready   (mem_wr_ready),
    .store_done     (store_done),
    .sat_count      (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] lanes(input logic [15:0] l0, l1, l2, l3, l4, l5, l6, l7);
    return {l7, l6, l5, l4, l3, l2, l1, l0};
  endfunction

  // Drives one store and observes it at falling edges. start_cyc counts the start cycle as 1.
  task automatic run_store(input logic [11:0] b, r, c, input logic [127:0] w, input int stall,
                           output int done_cyc, output int wr_cycles, output int done_pulses,
                           output logic [63:0] data, output logic [11:0] addr,
                           output logic [3:0] sat, output logic stable);
    int cyc;
    int after_done;
    done_cyc    = 0;
    wr_cycles   = 0;
    done_pulses = 0;
    data        = '0;
    addr        = '0;
    sat         = '0;
    stable      = 1'b1;
    after_done  = 0;
    @(negedge clk);
    base_addr      = b;
    row_offset     = r;
    col_offset     = c;
    pixel_word_in  = w;
    pixel_valid_in = 1'b1;
    store_en       = 1'b1;
    store_start    = 1'b1;
    mem_wr_ready   = (stall == 0);
    cyc = 1;
    while (cyc < 60 && after_done < 3) begin
      @(negedge clk);
      cyc++;
      store_start = 1'b0;
      if (mem_wr_en) begin
        wr_cycles++;
        pixel_valid_in = 1'b0;
        if (wr_cycles == 1) begin
          data = mem_wr_data;
          addr = mem_wr_addr;
          sat  = sat_count;
        end else if (mem_wr_data !== data || mem_wr_addr !== addr) begin
          stable = 1'b0;
        end
        mem_wr_ready = (wr_cycles > stall);
      end
      if (store_done) begin
        done_pulses++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_cyc != 0) after_done++;
    end
    if (done_cyc == 0) check("store_done_timeout", 64'(cyc), 64'd0);
    mem_wr_ready   = 1'b0;
    pixel_valid_in = 1'b0;
  endtask

  int          dcyc, wcyc, dpul;
  logic [63:0] d;
  logic [11:0] a;
  logic [3:0]  s;
  logic        st;
  int          seen_ready, seen_wr, seen_done;

  initial begin
    rst            = 1'b1;
    store_en       = 1'b0;
    store_start    = 1'b0;
    base_addr      = '0;
    row_offset     = '0;
    col_offset     = '0;
    pixel_word_in  = '0;
    pixel_valid_in = 1'b0;
    mem_wr_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(store_ready), 64'd0);
    check("rst_wr_en", 64'(mem_wr_en), 64'd0);
    check("rst_done", 64'(store_done), 64'd0);
    check("rst_addr", 64'(mem_wr_addr), 64'd0);
    check("rst_data", mem_wr_data, 64'd0);
    check("rst_sat", 64'(sat_count), 64'd0);
    rst = 1'b0;

    // Basic store
    run_store(12'h000, 12'h000, 12'h000, lanes(1, 2, 3, 4, 5, 6, 7, 8), 0, dcyc, wcyc, dpul, d, a, s, st);
    check("t1_addr", 64'(a), 64'h000);
    check("t1_data", d, 64'h0807060504030201);
    check("t1_sat", 64'(s), 64'd0);
    check("t1_latency", 64'(dcyc), 64'd4);
    check("t1_wr_cycles", 64'(wcyc), 64'd1);
    check("t1_done_pulses", 64'(dpul), 64'd1);

    // Clamping at both ends
    run_store(12'h010, 12'h020, 12'h004,
              lanes(-16'sd5, 16'sd300, 16'sd255, 16'sd0, 16'sd256, 16'h8000, 16'sd32767, 16'sd128),
              0, dcyc, wcyc, dpul, d, a, s, st);
    check("t2_addr", 64'(a), 64'h034);
    check("t2_data", d, 64'h80FF00FF00FFFF00);
    check("t2_sat", 64'(s), 64'd5);
    check("t2_hold_data", mem_wr_data, 64'h80FF00FF00FFFF00);

    // Address wrap
    run_store(12'hFFE, 12'h001, 12'h003, lanes(16'h00AA, 0, 0, 0, 0, 0, 0, 16'h0100),
              0, dcyc, wcyc, dpul, d, a, s, st);
    check("t3_addr", 64'(a), 64'h002);
    check("t3_data", d, 64'hFF000000000000AA);
    check("t3_sat", 64'(s), 64'd1);

    // Backpressure
    run_store(12'h100, 12'h010, 12'h001, lanes(10, 20, 30, 40, 50, 60, 70, 80),
              5, dcyc, wcyc, dpul, d, a, s, st);
    check("t4_wr_cycles", 64'(wcyc), 64'd6);
    check("t4_stable", 64'(st), 64'd1);
    check("t4_done_pulses", 64'(dpul), 64'd1);
    check("t4_latency", 64'(dcyc), 64'd9);
    check("t4_addr", 64'(a), 64'h111);
    check("t4_data", d, 64'h50463C32281E140A);

    // Start while disabled is ignored
    @(negedge clk);
    base_addr      = 12'h300;
    row_offset     = 12'h000;
    col_offset     = 12'h000;
    pixel_word_in  = lanes(9, 9, 9, 9, 9, 9, 9, 9);
    store_en       = 1'b0;
    store_start    = 1'b1;
    pixel_valid_in = 1'b1;
    mem_wr_ready   = 1'b1;
    seen_ready = 0; seen_wr = 0; seen_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      store_start = 1'b0;
      if (store_ready) seen_ready++;
      if (mem_wr_en) seen_wr++;
      if (store_done) seen_done++;
    end
    check("t5a_ready", 64'(seen_ready), 64'd0);
    check("t5a_wr_en", 64'(seen_wr), 64'd0);
    check("t5a_done", 64'(seen_done), 64'd0);

    // Enable dropped while waiting for data aborts the store
    pixel_valid_in = 1'b0;
    store_en       = 1'b1;
    store_start    = 1'b1;
    @(negedge clk);
    store_start = 1'b0;
    check("t5b_ready_on_entry", 64'(store_ready), 64'd1);
    store_en = 1'b0;
    @(negedge clk);
    pixel_valid_in = 1'b1;
    seen_ready = 0; seen_wr = 0; seen_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (store_ready) seen_ready++;
      if (mem_wr_en) seen_wr++;
      if (store_done) seen_done++;
    end
    check("t5b_ready_after", 64'(seen_ready), 64'd0);
    check("t5b_wr_en", 64'(seen_wr), 64'd0);
    check("t5b_done", 64'(seen_done), 64'd0);
    check("t5b_hold_addr", 64'(mem_wr_addr), 64'h111);
    pixel_valid_in = 1'b0;
    mem_wr_ready   = 1'b0;

    // Reset during WRITE
    @(negedge clk);
    base_addr      = 12'h050;
    pixel_word_in  = lanes(1, 1, 1, 1, 1, 1, 1, 1);
    store_en       = 1'b1;
    store_start    = 1'b1;
    pixel_valid_in = 1'b1;
    seen_wr = 0;
    for (int i = 0; i < 10 && seen_wr == 0; i++) begin
      @(negedge clk);
      store_start = 1'b0;
      if (mem_wr_en) seen_wr = 1;
    end
    check("t6_reached_write", 64'(seen_wr), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_wr_en_async", 64'(mem_wr_en), 64'd0);
    check("t6_done_async", 64'(store_done), 64'd0);
    check("t6_addr_async", 64'(mem_wr_addr), 64'd0);
    pixel_valid_in = 1'b0;
    seen_done = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (store_done || mem_wr_en) seen_done++;
    end
    check("t6_no_done", 64'(seen_done), 64'd0);
    run_store(12'h000, 12'h000, 12'h000, lanes(1, 2, 3, 4, 5, 6, 7, 8), 0, dcyc, wcyc, dpul, d, a, s, st);
    check("t6_after_data", d, 64'h0807060504030201);
    check("t6_after_latency", 64'(dcyc), 64'd4);
    check("t6_after_pulses", 64'(dpul), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
